// File: rtl/bkt_lvl_finder.sv
// Backtrack-level finder: scans one bin of learnt-literal levels, one cell per cycle,
// and reports the highest level, the second-highest distinct level, the count and an overflow flag.
module bkt_lvl_finder #(
   parameter int unsigned NUM_VARS  = 8,
   parameter int unsigned WIDTH_LVL = 10
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start_i,
   input  logic [NUM_VARS*WIDTH_LVL-1:0] var_levels_i,
   input  logic [NUM_VARS-1:0]           var_valid_i,
   input  logic [WIDTH_LVL-1:0]          cur_lvl_i,
   output logic                          busy_o,
   output logic                          done_o,
   output logic [WIDTH_LVL-1:0]          max_lvl_o,
   output logic [WIDTH_LVL-1:0]          bkt_lvl_o,
   output logic [7:0]                    lit_cnt_o,
   output logic                          err_o
);

   localparam int unsigned IDX_W = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VARS - 1);

   typedef enum logic [1:0] {StIdle, StScan, StDone} state_t;

   state_t                        r_state;
   logic [NUM_VARS*WIDTH_LVL-1:0] r_levels;
   logic [NUM_VARS-1:0]           r_valid;
   logic [WIDTH_LVL-1:0]          r_cur;
   logic [IDX_W-1:0]              r_idx;
   logic [WIDTH_LVL-1:0]          r_max;
   logic [WIDTH_LVL-1:0]          r_second;
   logic [7:0]                    r_cnt;
   logic                          r_err;

   logic                          r_busy;
   logic                          r_done;
   logic [WIDTH_LVL-1:0]          r_max_out;
   logic [WIDTH_LVL-1:0]          r_bkt_out;
   logic [7:0]                    r_cnt_out;
   logic                          r_err_out;

   logic [WIDTH_LVL-1:0]          w_lvl;
   logic                          w_vld;
   logic [WIDTH_LVL-1:0]          w_max_nxt;
   logic [WIDTH_LVL-1:0]          w_sec_nxt;
   logic [7:0]                    w_cnt_nxt;
   logic                          w_err_nxt;

   assign w_lvl = r_levels[r_idx*WIDTH_LVL +: WIDTH_LVL];
   assign w_vld = r_valid[r_idx];

   // Second tracks the highest level strictly below max, so duplicates of max never land in it.
   always_comb begin
      w_max_nxt = r_max;
      w_sec_nxt = r_second;
      w_cnt_nxt = r_cnt;
      w_err_nxt = r_err;
      if (w_vld) begin
         if (w_lvl > r_max) begin
            w_sec_nxt = r_max;
            w_max_nxt = w_lvl;
         end else if ((w_lvl < r_max) && (w_lvl > r_second)) begin
            w_sec_nxt = w_lvl;
         end
         if (r_cnt != 8'hFF) begin
            w_cnt_nxt = r_cnt + 8'd1;
         end
         if (w_lvl > r_cur) begin
            w_err_nxt = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= StIdle;
         r_levels  <= '0;
         r_valid   <= '0;
         r_cur     <= '0;
         r_idx     <= '0;
         r_max     <= '0;
         r_second  <= '0;
         r_cnt     <= '0;
         r_err     <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_max_out <= '0;
         r_bkt_out <= '0;
         r_cnt_out <= '0;
         r_err_out <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (start_i) begin
                  r_levels <= var_levels_i;
                  r_valid  <= var_valid_i;
                  r_cur    <= cur_lvl_i;
                  r_idx    <= '0;
                  r_max    <= '0;
                  r_second <= '0;
                  r_cnt    <= '0;
                  r_err    <= 1'b0;
                  r_busy   <= 1'b1;
                  r_state  <= StScan;
               end
            end
            StScan: begin
               r_max    <= w_max_nxt;
               r_second <= w_sec_nxt;
               r_cnt    <= w_cnt_nxt;
               r_err    <= w_err_nxt;
               if (r_idx == LAST_IDX) begin
                  r_state <= StDone;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            StDone: begin
               r_done    <= 1'b1;
               r_max_out <= r_max;
               r_bkt_out <= r_second;
               r_cnt_out <= r_cnt;
               r_err_out <= r_err;
               r_busy    <= 1'b0;
               r_state   <= StIdle;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign busy_o    = r_busy;
   assign done_o    = r_done;
   assign max_lvl_o = r_max_out;
   assign bkt_lvl_o = r_bkt_out;
   assign lit_cnt_o = r_cnt_out;
   assign err_o     = r_err_out;

endmodule

// File: tb/tb_bkt_lvl_finder.sv
// Directed and random bench for bkt_lvl_finder; expected results go through a scoreboard queue
// and are popped by a monitor on every done_o pulse.
module tb_bkt_lvl_finder;

   localparam int unsigned NV = 8;
   localparam int unsigned WL = 10;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start_i;
   logic [NV*WL-1:0]  var_levels_i;
   logic [NV-1:0]     var_valid_i;
   logic [WL-1:0]     cur_lvl_i;
   logic              busy_o;
   logic              done_o;
   logic [WL-1:0]     max_lvl_o;
   logic [WL-1:0]     bkt_lvl_o;
   logic [7:0]        lit_cnt_o;
   logic              err_o;

   typedef struct {
      logic [WL-1:0] max;
      logic [WL-1:0] bkt;
      logic [7:0]    cnt;
      logic          err;
      int            cyc;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   cyc    = 0;

   bkt_lvl_finder #(.NUM_VARS(NV), .WIDTH_LVL(WL)) dut (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start_i),
      .var_levels_i (var_levels_i),
      .var_valid_i  (var_valid_i),
      .cur_lvl_i    (cur_lvl_i),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .max_lvl_o    (max_lvl_o),
      .bkt_lvl_o    (bkt_lvl_o),
      .lit_cnt_o    (lit_cnt_o),
      .err_o        (err_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NV*WL-1:0] pk(input int unsigned l0, input int unsigned l1,
                                           input int unsigned l2, input int unsigned l3,
                                           input int unsigned l4, input int unsigned l5,
                                           input int unsigned l6, input int unsigned l7);
      return {WL'(l7), WL'(l6), WL'(l5), WL'(l4), WL'(l3), WL'(l2), WL'(l1), WL'(l0)};
   endfunction

   // Reference: max over valid cells, then max over valid cells strictly below that.
   function automatic exp_t model(input logic [NV*WL-1:0] lv, input logic [NV-1:0] vl,
                                  input logic [WL-1:0] cur);
      exp_t e;
      logic [WL-1:0] l;
      int n;
      e.max = '0;
      e.bkt = '0;
      e.err = 1'b0;
      e.cyc = 0;
      n = 0;
      for (int k = 0; k < int'(NV); k++) begin
         l = lv[k*WL +: WL];
         if (vl[k]) begin
            n++;
            if (l > e.max) e.max = l;
            if (l > cur) e.err = 1'b1;
         end
      end
      for (int k = 0; k < int'(NV); k++) begin
         l = lv[k*WL +: WL];
         if (vl[k] && (l < e.max) && (l > e.bkt)) e.bkt = l;
      end
      e.cnt = (n > 255) ? 8'd255 : 8'(n);
      return e;
   endfunction

   // Called just after a negedge; start_i is sampled at the following posedge (edge N).
   task automatic start_search(input logic [NV*WL-1:0] lv, input logic [NV-1:0] vl,
                               input logic [WL-1:0] cur);
      exp_t e;
      var_levels_i = lv;
      var_valid_i  = vl;
      cur_lvl_i    = cur;
      start_i      = 1'b1;
      @(posedge clk);
      #1;
      e     = model(lv, vl, cur);
      e.cyc = cyc + int'(NV) + 1;
      sb.push_back(e);
      start_i = 1'b0;
      chk("busy_after_start", 32'(busy_o), 32'd1);
   endtask

   task automatic wait_done();
      for (int i = 0; i < 30 && sb.size() != 0; i++) begin
         @(negedge clk);
         #1;
      end
      chk("done_timeout_pending", sb.size(), 0);
   endtask

   task automatic chk_res(input string tag, input logic [WL-1:0] mx, input logic [WL-1:0] bk,
                          input logic [7:0] cn, input logic er);
      chk({tag, "_max"}, 32'(max_lvl_o), 32'(mx));
      chk({tag, "_bkt"}, 32'(bkt_lvl_o), 32'(bk));
      chk({tag, "_cnt"}, 32'(lit_cnt_o), 32'(cn));
      chk({tag, "_err"}, 32'(err_o), 32'(er));
   endtask

   always @(negedge clk) begin
      if (rst === 1'b1 && done_o === 1'b1) begin
         if (sb.size() == 0) begin
            chk("spurious_done", 32'(done_o), 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("done_cycle", cyc, e.cyc);
            chk("sb_max", 32'(max_lvl_o), 32'(e.max));
            chk("sb_bkt", 32'(bkt_lvl_o), 32'(e.bkt));
            chk("sb_cnt", 32'(lit_cnt_o), 32'(e.cnt));
            chk("sb_err", 32'(err_o), 32'(e.err));
         end
      end
   end

   initial begin
      start_i      = 1'b0;
      var_levels_i = '0;
      var_valid_i  = '0;
      cur_lvl_i    = '0;
      #1 rst = 1'b0;
      #2;
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_done", 32'(done_o), 32'd0);
      chk_res("rst", 10'd0, 10'd0, 8'd0, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk("idle_busy", 32'(busy_o), 32'd0);

      // Two cells share max 7; backtrack level is 5.
      start_search(pk(3, 7, 5, 7, 0, 0, 0, 0), 8'h0F, 10'd7);
      wait_done();
      @(negedge clk);
      chk_res("basic_hold", 10'd7, 10'd5, 8'd4, 1'b0);
      chk("done_one_cycle", 32'(done_o), 32'd0);
      chk("busy_after_done", 32'(busy_o), 32'd0);

      start_search(pk(3, 7, 5, 7, 9, 9, 9, 9), 8'h00, 10'd7);
      wait_done();
      chk_res("novalid", 10'd0, 10'd0, 8'd0, 1'b0);

      start_search(pk(0, 0, 4, 0, 0, 0, 0, 0), 8'h04, 10'd4);
      wait_done();
      chk_res("single", 10'd4, 10'd0, 8'd1, 1'b0);

      start_search(pk(0, 0, 0, 0, 0, 9, 0, 0), 8'h20, 10'd6);
      wait_done();
      chk_res("single_err", 10'd9, 10'd0, 8'd1, 1'b1);

      // Inputs change and start re-asserts mid-search; only the snapshot counts.
      start_search(pk(2, 6, 1, 6, 3, 0, 5, 4), 8'hFF, 10'd6);
      @(posedge clk);
      #1;
      var_levels_i = pk(100, 200, 300, 400, 500, 600, 700, 800);
      var_valid_i  = 8'hFF;
      cur_lvl_i    = 10'd1;
      @(posedge clk);
      #1;
      start_i = 1'b1;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      chk("busy_ignored_start", 32'(busy_o), 32'd1);
      wait_done();
      repeat (12) @(negedge clk);
      chk_res("snapshot", 10'd6, 10'd5, 8'd8, 1'b0);

      // Full-width unsigned compare.
      start_search(pk(1023, 512, 1000, 0, 511, 1023, 7, 1), 8'hB3, 10'd1000);
      wait_done();
      chk_res("unsigned", 10'd1023, 10'd512, 8'd5, 1'b1);

      // Back-to-back: second search uses smaller levels so stale state would show.
      start_search(pk(9, 8, 9, 8, 9, 8, 9, 8), 8'hFF, 10'd9);
      for (int i = 0; i < 30 && done_o !== 1'b1; i++) @(negedge clk);
      chk("b2b_first_done", 32'(done_o), 32'd1);
      start_search(pk(2, 1, 0, 0, 0, 0, 0, 0), 8'h03, 10'd1);
      wait_done();
      chk_res("b2b", 10'd2, 10'd1, 8'd2, 1'b1);

      // Reset mid-search: outputs clear at once and the aborted search never completes.
      start_search(pk(5, 4, 3, 2, 1, 0, 0, 0), 8'h1F, 10'd5);
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy_o), 32'd0);
      chk("midrst_done", 32'(done_o), 32'd0);
      chk_res("midrst", 10'd0, 10'd0, 8'd0, 1'b0);
      sb.delete();
      @(negedge clk);
      rst = 1'b1;
      repeat (12) @(negedge clk);
      chk("midrst_no_done", 32'(lit_cnt_o), 32'd0);
      #1;
      start_search(pk(5, 4, 3, 2, 1, 0, 0, 0), 8'h1F, 10'd5);
      wait_done();
      chk_res("after_rst", 10'd5, 10'd4, 8'd5, 1'b0);

      for (int r = 0; r < 6; r++) begin
         logic [NV*WL-1:0] lv;
         for (int k = 0; k < int'(NV); k++) lv[k*WL +: WL] = WL'($urandom_range(0, 15));
         start_search(lv, 8'($urandom), WL'($urandom_range(0, 15)));
         wait_done();
      end

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
